// File: rtl/midi_voice_release_if.sv
// Note-on commit / note-off request bundle between the voice pool control and the release block.
interface midi_voice_release_if #(
  parameter int NUM_VOICES = 32,
  parameter int KEY_BITS   = 7
);
  localparam int IDX_BITS = $clog2(NUM_VOICES);

  logic                  on_valid;
  logic [IDX_BITS-1:0]   on_voice;
  logic [KEY_BITS-1:0]   on_key;
  logic                  off_valid;
  logic [KEY_BITS-1:0]   off_key;
  logic                  off_ready;
  logic [NUM_VOICES-1:0] notes_playing;
  logic                  done;
  logic                  found;
  logic [IDX_BITS-1:0]   freed_voice;

  modport master (
    output on_valid, on_voice, on_key, off_valid, off_key,
    input  off_ready, notes_playing, done, found, freed_voice
  );

  modport slave (
    input  on_valid, on_voice, on_key, off_valid, off_key,
    output off_ready, notes_playing, done, found, freed_voice
  );
endinterface

// File: rtl/midi_voice_release.sv
// Note-off side of the voice pool: tracks playing voices and their keys, and frees
// the lowest-index voice holding the requested key with a one-voice-per-cycle scan.
module midi_voice_release #(
  parameter int NUM_VOICES = 32,
  parameter int KEY_BITS   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  midi_voice_release_if.slave   bus
);
  localparam int IDX_BITS = $clog2(NUM_VOICES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_reg;
  logic [KEY_BITS-1:0]   key_tbl [NUM_VOICES];
  logic [NUM_VOICES-1:0] notes_playing_reg;
  logic [NUM_VOICES-1:0] notes_playing_next;
  logic [NUM_VOICES-1:0] key_hit;
  logic [NUM_VOICES-1:0] clear_mask;
  logic [NUM_VOICES-1:0] set_mask;
  logic [KEY_BITS-1:0]   tgt_key_reg;
  logic [IDX_BITS-1:0]   idx_reg;
  logic                  off_ready_reg;
  logic                  done_reg;
  logic                  found_reg;
  logic [IDX_BITS-1:0]   freed_voice_reg;
  logic                  match;

  // Idle voices never match, regardless of the stale key left in their slot.
  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_hit
      assign key_hit[gi] = notes_playing_reg[gi] && (key_tbl[gi] == tgt_key_reg);
    end
  endgenerate

  assign match = key_hit[idx_reg];

  // Release clears first and note-on sets after, so a same-edge note-on keeps the voice alive.
  always_comb begin
    clear_mask = '0;
    set_mask   = '0;
    if (state_reg == SCAN && match) clear_mask[idx_reg] = 1'b1;
    if (bus.on_valid)               set_mask[bus.on_voice] = 1'b1;
    notes_playing_next = (notes_playing_reg & ~clear_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) key_tbl[i] <= '0;
    end else if (bus.on_valid) begin
      key_tbl[bus.on_voice] <= bus.on_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      notes_playing_reg <= '0;
      tgt_key_reg       <= '0;
      idx_reg           <= '0;
      off_ready_reg     <= 1'b1;
      done_reg          <= 1'b0;
      found_reg         <= 1'b0;
      freed_voice_reg   <= '0;
    end else begin
      notes_playing_reg <= notes_playing_next;
      done_reg          <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.off_valid && off_ready_reg) begin
            tgt_key_reg     <= bus.off_key;
            idx_reg         <= '0;
            found_reg       <= 1'b0;
            freed_voice_reg <= '0;
            off_ready_reg   <= 1'b0;
            state_reg       <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            found_reg       <= 1'b1;
            freed_voice_reg <= idx_reg;
            done_reg        <= 1'b1;
            state_reg       <= DONE;
          end else if (idx_reg == LAST_IDX) begin
            found_reg <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          off_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          off_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.off_ready     = off_ready_reg;
  assign bus.notes_playing = notes_playing_reg;
  assign bus.done          = done_reg;
  assign bus.found         = found_reg;
  assign bus.freed_voice   = freed_voice_reg;
endmodule

// File: tb/tb_midi_voice_release.sv
// Directed bench for midi_voice_release: a vector table of note-on/note-off
// transactions plus hand-written sequences for same-edge steal, held requests and mid-scan reset.
module tb_midi_voice_release;
  logic clk = 1'b0;
  logic reset = 1'b0;

  midi_voice_release_if bus ();

  midi_voice_release dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_off;
    int          voice;
    int          key;
    bit          exp_found;
    int          exp_freed;
    int          exp_lat;
    logic [31:0] exp_bitmap;
  } vec_t;

  vec_t vecs[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add_vec(bit is_off, int voice, int key, bit f, int fr, int lat, logic [31:0] bm);
    vec_t v;
    v.is_off = is_off; v.voice = voice; v.key = key;
    v.exp_found = f; v.exp_freed = fr; v.exp_lat = lat; v.exp_bitmap = bm;
    vecs.push_back(v);
  endfunction

  task automatic note_on(input int voice, input int key);
    bus.on_valid = 1'b1;
    bus.on_voice = 5'(voice);
    bus.on_key   = 7'(key);
    step();
    bus.on_valid = 1'b0;
  endtask

  // Latency is counted in cycles from the accept cycle (accept cycle = 0) to the done cycle.
  task automatic do_off(input int key, input int inj_cycle, input int inj_voice, input int inj_key,
                        input bit hold, input int next_key,
                        output bit f, output int fr, output int lat, output int viol);
    int w;
    int cnt;
    bus.off_key   = 7'(key);
    bus.off_valid = 1'b1;
    w = 0;
    while (!bus.off_ready && w < 50) begin
      step();
      w++;
    end
    step();
    bus.off_valid = hold;
    bus.off_key   = 7'(next_key);
    cnt  = 0;
    viol = 0;
    while (!bus.done && cnt < 40) begin
      if (cnt == inj_cycle) begin
        bus.on_valid = 1'b1;
        bus.on_voice = 5'(inj_voice);
        bus.on_key   = 7'(inj_key);
      end
      if (bus.off_ready) viol++;
      step();
      bus.on_valid = 1'b0;
      cnt++;
    end
    f   = bus.found;
    fr  = int'(bus.freed_voice);
    lat = cnt + 1;
  endtask

  task automatic off_and_check(input string tag, input int key, input int inj_cycle, input int inj_voice,
                               input int inj_key, input bit hold, input int next_key,
                               input bit ef, input int efr, input int elat, input logic [31:0] ebm);
    bit f;
    int fr, lat, viol;
    do_off(key, inj_cycle, inj_voice, inj_key, hold, next_key, f, fr, lat, viol);
    $display("off %s key=%0d found=%0d freed=%0d lat=%0d bitmap=%08h", tag, key, f, fr, lat, bus.notes_playing);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " found"}, 32'(f), 32'(ef));
    check({tag, " freed_voice"}, 32'(fr), 32'(efr));
    check({tag, " bitmap"}, bus.notes_playing, ebm);
    check({tag, " ready_low_in_scan"}, 32'(viol), 32'd0);
    step();
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, " ready_after_done"}, 32'(bus.off_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    bus.on_valid = 1'b0; bus.on_voice = '0; bus.on_key = '0;
    bus.off_valid = 1'b0; bus.off_key = '0;

    add_vec(1, 0, 60, 0, 0, 33, 32'h0000_0000);
    add_vec(0, 0, 60, 0, 0, 0,  32'h0000_0001);
    add_vec(1, 0, 60, 1, 0, 2,  32'h0000_0000);
    add_vec(0, 5, 64, 0, 0, 0,  32'h0000_0020);
    add_vec(0, 31, 64, 0, 0, 0, 32'h8000_0020);
    add_vec(1, 0, 64, 1, 5, 7,  32'h8000_0000);
    add_vec(1, 0, 64, 1, 31, 33, 32'h0000_0000);
    add_vec(0, 7, 0, 0, 0, 0,   32'h0000_0080);
    add_vec(0, 9, 0, 0, 0, 0,   32'h0000_0280);
    add_vec(1, 0, 0, 1, 7, 9,   32'h0000_0200);
    add_vec(0, 9, 12, 0, 0, 0,  32'h0000_0200);
    add_vec(1, 0, 0, 0, 0, 33,  32'h0000_0200);
    add_vec(1, 0, 12, 1, 9, 11, 32'h0000_0000);

    step(); step();
    reset = 1'b1;
    step();
    $display("reset bitmap=%08h ready=%0d done=%0d", bus.notes_playing, bus.off_ready, bus.done);
    check("reset bitmap", bus.notes_playing, 32'h0);
    check("reset off_ready", 32'(bus.off_ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset found", 32'(bus.found), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_off) begin
        off_and_check($sformatf("vec%0d", i), vecs[i].key, -1, 0, 0, 1'b0, 0,
                      vecs[i].exp_found, vecs[i].exp_freed, vecs[i].exp_lat, vecs[i].exp_bitmap);
      end else begin
        note_on(vecs[i].voice, vecs[i].key);
        $display("on vec%0d voice=%0d key=%0d bitmap=%08h", i, vecs[i].voice, vecs[i].key, bus.notes_playing);
        check($sformatf("vec%0d on bitmap", i), bus.notes_playing, vecs[i].exp_bitmap);
      end
    end

    // Note-on to voice 3 on the same edge that releases it: voice stays playing with key 70.
    note_on(3, 67);
    off_and_check("steal_same_edge", 67, 3, 3, 70, 1'b0, 0, 1'b1, 3, 5, 32'h0000_0008);
    off_and_check("steal_new_key", 70, -1, 0, 0, 1'b0, 0, 1'b1, 3, 5, 32'h0000_0000);

    // Held off_valid: second request (key 62) must wait for the first to finish.
    note_on(2, 62);
    off_and_check("hold_first", 60, -1, 0, 0, 1'b1, 62, 1'b0, 0, 33, 32'h0000_0004);
    off_and_check("hold_second", 62, -1, 0, 0, 1'b0, 0, 1'b1, 2, 4, 32'h0000_0000);

    // Reset mid-scan: slots 0..10 hold key 1 so a key-0 scan is still running at idx 10.
    for (int v = 0; v < 32; v++) note_on(v, (v <= 10) ? 1 : 0);
    check("all playing", bus.notes_playing, 32'hFFFF_FFFF);
    bus.off_key = 7'd0;
    bus.off_valid = 1'b1;
    step();
    bus.off_valid = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) done_seen++;
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    if (bus.done) done_seen++;
    $display("midscan_reset bitmap=%08h ready=%0d done=%0d", bus.notes_playing, bus.off_ready, bus.done);
    check("midscan_reset bitmap", bus.notes_playing, 32'h0);
    check("midscan_reset off_ready", 32'(bus.off_ready), 32'd1);
    check("midscan_reset found", 32'(bus.found), 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (bus.done) done_seen++;
      step();
    end
    check("midscan_reset no_done", 32'(done_seen), 32'd0);
    off_and_check("after_reset", 0, -1, 0, 0, 1'b0, 0, 1'b0, 0, 33, 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
